// File: rtl/display_pkg.sv
// Shared types and constants for the two-digit display multiplexer.
package display_pkg;

   // Slot order is fixed: dead time before each lit digit.
   typedef enum logic [1:0] {
      BLANK0 = 2'd0,
      SHOW0  = 2'd1,
      BLANK1 = 2'd2,
      SHOW1  = 2'd3
   } mux_state_t;

   localparam int          CNT_W   = 24;
   localparam int unsigned CNT_MAX = (32'd1 << CNT_W) - 32'd1;

endpackage : display_pkg

// File: rtl/display_mux_slot_timer.sv
// Slot length counter: counts 0 .. limit-1 and flags the final cycle of a slot.
module slot_timer
   import display_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [CNT_W-1:0] limit,
   output logic             tc
);

   logic [CNT_W-1:0] r_cnt;

   // Terminal count is the last cycle of the current slot; limit is never 0.
   assign tc = (r_cnt == (limit - CNT_W'(1)));

   // Count up within a slot and restart at zero when the slot ends.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of block ordering.
      if (reset) begin
         r_cnt <= '0;
      end else if (tc) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule : slot_timer

// File: rtl/display_mux.sv
// Time-multiplexes two hex nibbles onto one seven-segment bus with dead time
// before each lit slot. Anodes are active-low (PNP drivers).
module display_mux
   import display_pkg::*;
#(
   parameter int unsigned SHOW_CYCLES  = 48000,
   parameter int unsigned BLANK_CYCLES = 480
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] s0,
   input  logic [3:0] s1,
   output logic [3:0] s_sel,
   output logic       an0_n,
   output logic       an1_n,
   output logic       digit
);

   // Reject out-of-range slot lengths at elaboration.
   if ((SHOW_CYCLES < 1) || (SHOW_CYCLES > CNT_MAX)) begin : g_bad_show
      $error("display_mux: SHOW_CYCLES must be in 1 .. 2^24-1");
   end
   if ((BLANK_CYCLES < 2) || (BLANK_CYCLES > CNT_MAX)) begin : g_bad_blank
      $error("display_mux: BLANK_CYCLES must be in 2 .. 2^24-1");
   end

   localparam logic [CNT_W-1:0] SHOW_L  = CNT_W'(SHOW_CYCLES);
   localparam logic [CNT_W-1:0] BLANK_L = CNT_W'(BLANK_CYCLES);

   mux_state_t       r_state;
   logic [3:0]       r_sel;
   logic             r_an0_n;
   logic             r_an1_n;
   logic             r_digit;
   logic [CNT_W-1:0] w_limit;
   logic             w_tc;

   // Slot length follows the current state only.
   assign w_limit = ((r_state == SHOW0) || (r_state == SHOW1)) ? SHOW_L : BLANK_L;

   slot_timer u_slot_timer (
      .clk   (clk),
      .reset (reset),
      .limit (w_limit),
      .tc    (w_tc)
   );

   // Slot sequencer with registered anode/digit outputs and the nibble latch.
   // The nibble is only sampled during the blank slot ahead of its digit, and
   // never on the blank slot's last edge, so it is settled before lighting.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= BLANK0;
         r_sel   <= 4'h0;
         r_an0_n <= 1'b1;
         r_an1_n <= 1'b1;
         r_digit <= 1'b0;
      end else begin
         if ((r_state == BLANK0) && !w_tc) begin
            r_sel <= s0;
         end else if ((r_state == BLANK1) && !w_tc) begin
            r_sel <= s1;
         end

         if (w_tc) begin
            case (r_state)
               BLANK0: begin
                  r_state <= SHOW0;
                  r_an0_n <= 1'b0;
               end
               SHOW0: begin
                  r_state <= BLANK1;
                  r_an0_n <= 1'b1;
                  r_digit <= 1'b1;
               end
               BLANK1: begin
                  r_state <= SHOW1;
                  r_an1_n <= 1'b0;
               end
               SHOW1: begin
                  r_state <= BLANK0;
                  r_an1_n <= 1'b1;
                  r_digit <= 1'b0;
               end
               default: begin
                  r_state <= BLANK0;
                  r_an0_n <= 1'b1;
                  r_an1_n <= 1'b1;
                  r_digit <= 1'b0;
               end
            endcase
         end
      end
   end

   assign s_sel = r_sel;
   assign an0_n = r_an0_n;
   assign an1_n = r_an1_n;
   assign digit = r_digit;

endmodule : display_mux

// File: tb/tb_display_mux.sv
// Self-checking bench for display_mux: two instances (4/2 and 1/2 slot lengths)
// compared each cycle against a phase-arithmetic model of the slot schedule.
module tb_display_mux;

   localparam int S_A = 4;
   localparam int B_A = 2;
   localparam int P_A = 2 * (S_A + B_A);
   localparam int S_B = 1;
   localparam int B_B = 2;
   localparam int P_B = 2 * (S_B + B_B);

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] s0, s1;
   logic [3:0] a_sel, b_sel;
   logic       a_an0_n, a_an1_n, a_digit;
   logic       b_an0_n, b_an1_n, b_digit;

   int n_checks = 0;
   int n_errors = 0;

   // Model: phase within the period after the most recent edge, and the nibble
   // the bus should carry.
   int         ph_a, ph_b;
   logic [3:0] m_sel_a, m_sel_b;

   always #5 clk = ~clk;

   display_mux #(.SHOW_CYCLES(S_A), .BLANK_CYCLES(B_A)) dut_a (
      .clk(clk), .reset(reset), .s0(s0), .s1(s1),
      .s_sel(a_sel), .an0_n(a_an0_n), .an1_n(a_an1_n), .digit(a_digit)
   );

   display_mux #(.SHOW_CYCLES(S_B), .BLANK_CYCLES(B_B)) dut_b (
      .clk(clk), .reset(reset), .s0(s0), .s1(s1),
      .s_sel(b_sel), .an0_n(b_an0_n), .an1_n(b_an1_n), .digit(b_digit)
   );

   // Expected {an0_n, an1_n, digit} for a phase: BLANK0, SHOW0, BLANK1, SHOW1.
   function automatic logic [2:0] exp_out(int ph, int s, int b);
      if (ph < b)              return 3'b110;
      else if (ph < b + s)     return 3'b010;
      else if (ph < 2 * b + s) return 3'b111;
      else                     return 3'b101;
   endfunction

   // Advance one clock edge and update the model from the pre-edge inputs.
   task automatic tick();
      logic       rst_pre;
      logic [3:0] s0_pre, s1_pre;
      rst_pre = reset;
      s0_pre  = s0;
      s1_pre  = s1;
      @(posedge clk);
      #1;
      if (rst_pre) begin
         ph_a = 0; m_sel_a = 4'h0;
         ph_b = 0; m_sel_b = 4'h0;
      end else begin
         if (ph_a < B_A - 1) m_sel_a = s0_pre;
         else if (ph_a >= B_A + S_A && ph_a < 2 * B_A + S_A - 1) m_sel_a = s1_pre;
         ph_a = (ph_a + 1) % P_A;
         if (ph_b < B_B - 1) m_sel_b = s0_pre;
         else if (ph_b >= B_B + S_B && ph_b < 2 * B_B + S_B - 1) m_sel_b = s1_pre;
         ph_b = (ph_b + 1) % P_B;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; s0 = 4'h5; s1 = 4'h6;
      repeat (3) tick();
      n_checks++;
      if ({a_an0_n, a_an1_n, a_digit, a_sel} !== 7'b110_0000) begin
         n_errors++;
         $display("FAIL reset_a: got %b required %b", {a_an0_n, a_an1_n, a_digit, a_sel}, 7'b110_0000);
      end
      n_checks++;
      if ({b_an0_n, b_an1_n, b_digit, b_sel} !== 7'b110_0000) begin
         n_errors++;
         $display("FAIL reset_b: got %b required %b", {b_an0_n, b_an1_n, b_digit, b_sel}, 7'b110_0000);
      end
   endtask

   task automatic test_basic();
      reset = 1'b1; tick();
      s0 = 4'h3; s1 = 4'hA; reset = 1'b0;
      for (int e = 1; e <= 12; e++) begin
         tick();
         n_checks++;
         if ({a_an0_n, a_an1_n, a_digit, a_sel} !== {exp_out(ph_a, S_A, B_A), m_sel_a}) begin
            n_errors++;
            $display("FAIL basic_model edge %0d: got %b required %b", e,
                     {a_an0_n, a_an1_n, a_digit, a_sel}, {exp_out(ph_a, S_A, B_A), m_sel_a});
         end
         if (e == 1 || e == 7) begin
            n_checks++;
            if (a_sel !== ((e == 1) ? 4'h3 : 4'hA)) begin
               n_errors++;
               $display("FAIL basic_sel edge %0d: got %h required %h", e, a_sel, (e == 1) ? 4'h3 : 4'hA);
            end
         end
         if (e >= 2 && e <= 5) begin
            n_checks++;
            if ({a_an0_n, a_an1_n} !== 2'b01) begin
               n_errors++;
               $display("FAIL basic_show0 edge %0d: got %b required 01", e, {a_an0_n, a_an1_n});
            end
         end
         if (e >= 8 && e <= 11) begin
            n_checks++;
            if ({a_an0_n, a_an1_n} !== 2'b10) begin
               n_errors++;
               $display("FAIL basic_show1 edge %0d: got %b required 10", e, {a_an0_n, a_an1_n});
            end
         end
         if (e == 6 || e == 7 || e == 12) begin
            n_checks++;
            if ({a_an0_n, a_an1_n, a_digit} !== ((e == 12) ? 3'b110 : 3'b111)) begin
               n_errors++;
               $display("FAIL basic_blank edge %0d: got %b required %b", e,
                        {a_an0_n, a_an1_n, a_digit}, (e == 12) ? 3'b110 : 3'b111);
            end
         end
      end
   endtask

   task automatic test_freeze();
      reset = 1'b1; tick();
      s0 = 4'h3; s1 = 4'hA; reset = 1'b0;
      for (int e = 1; e <= 14; e++) begin
         tick();
         if (e == 3) s0 = 4'hF;
         n_checks++;
         if ({a_an0_n, a_an1_n, a_digit, a_sel} !== {exp_out(ph_a, S_A, B_A), m_sel_a}) begin
            n_errors++;
            $display("FAIL freeze_model edge %0d: got %b required %b", e,
                     {a_an0_n, a_an1_n, a_digit, a_sel}, {exp_out(ph_a, S_A, B_A), m_sel_a});
         end
         if (e >= 3 && e <= 5) begin
            n_checks++;
            if (a_sel !== 4'h3) begin
               n_errors++;
               $display("FAIL freeze_hold edge %0d: got %h required 3", e, a_sel);
            end
         end
      end
      n_checks++;
      if ({a_an0_n, a_sel} !== 5'b0_1111) begin
         n_errors++;
         $display("FAIL freeze_reload: got an0_n=%b sel=%h required an0_n=0 sel=f", a_an0_n, a_sel);
      end
   endtask

   task automatic test_random();
      logic       p0, p1;
      logic [3:0] psel;
      int         run0, run1, hi_run;
      reset = 1'b1; tick(); reset = 1'b0;
      p0 = 1'b1; p1 = 1'b1; psel = a_sel; run0 = 0; run1 = 0; hi_run = 1;
      for (int k = 0; k < 100 * P_A; k++) begin
         s0 = 4'($urandom); s1 = 4'($urandom);
         tick();
         n_checks++;
         if ({a_an0_n, a_an1_n, a_digit, a_sel} !== {exp_out(ph_a, S_A, B_A), m_sel_a}) begin
            n_errors++;
            $display("FAIL random_model cycle %0d: got %b required %b", k,
                     {a_an0_n, a_an1_n, a_digit, a_sel}, {exp_out(ph_a, S_A, B_A), m_sel_a});
         end
         n_checks++;
         if (!a_an0_n && !a_an1_n) begin
            n_errors++;
            $display("FAIL random_overlap cycle %0d: got both anodes low required at most one", k);
         end
         if ((!a_an0_n && !p0) || (!a_an1_n && !p1)) begin
            n_checks++;
            if (a_sel !== psel) begin
               n_errors++;
               $display("FAIL random_lit_stable cycle %0d: got %h required %h", k, a_sel, psel);
            end
         end
         if (!a_an0_n) run0++;
         else if (!p0) begin
            n_checks++;
            if (run0 != S_A) begin
               n_errors++;
               $display("FAIL random_run0 cycle %0d: got %0d required %0d", k, run0, S_A);
            end
            run0 = 0;
         end
         if (!a_an1_n) run1++;
         else if (!p1) begin
            n_checks++;
            if (run1 != S_A) begin
               n_errors++;
               $display("FAIL random_run1 cycle %0d: got %0d required %0d", k, run1, S_A);
            end
            run1 = 0;
         end
         if (a_an0_n && a_an1_n) hi_run++;
         else begin
            if (p0 && p1) begin
               n_checks++;
               if (hi_run < B_A) begin
                  n_errors++;
                  $display("FAIL random_deadtime cycle %0d: got %0d required >= %0d", k, hi_run, B_A);
               end
            end
            hi_run = 0;
         end
         p0 = a_an0_n; p1 = a_an1_n; psel = a_sel;
      end
   endtask

   task automatic test_reset_mid();
      reset = 1'b1; tick();
      s0 = 4'h3; s1 = 4'hA; reset = 1'b0;
      repeat (8) tick();
      n_checks++;
      if ({a_an0_n, a_an1_n} !== 2'b10) begin
         n_errors++;
         $display("FAIL midreset_pre: got %b required 10", {a_an0_n, a_an1_n});
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_checks++;
      if ({a_an0_n, a_an1_n, a_digit, a_sel} !== 7'b110_0000) begin
         n_errors++;
         $display("FAIL midreset_edge9: got %b required %b", {a_an0_n, a_an1_n, a_digit, a_sel}, 7'b110_0000);
      end
      for (int e = 1; e <= 12; e++) begin
         tick();
         n_checks++;
         if ({a_an0_n, a_an1_n, a_digit, a_sel} !== {exp_out(ph_a, S_A, B_A), m_sel_a}) begin
            n_errors++;
            $display("FAIL midreset_restart edge %0d: got %b required %b", e,
                     {a_an0_n, a_an1_n, a_digit, a_sel}, {exp_out(ph_a, S_A, B_A), m_sel_a});
         end
      end
   endtask

   task automatic test_corner();
      int run0, run1;
      logic p0, p1;
      reset = 1'b1; tick(); reset = 1'b0;
      run0 = 0; run1 = 0; p0 = 1'b1; p1 = 1'b1;
      for (int k = 0; k < 20 * P_B; k++) begin
         s0 = 4'($urandom); s1 = 4'($urandom);
         tick();
         n_checks++;
         if ({b_an0_n, b_an1_n, b_digit, b_sel} !== {exp_out(ph_b, S_B, B_B), m_sel_b}) begin
            n_errors++;
            $display("FAIL corner_model cycle %0d: got %b required %b", k,
                     {b_an0_n, b_an1_n, b_digit, b_sel}, {exp_out(ph_b, S_B, B_B), m_sel_b});
         end
         if (!b_an0_n) run0++;
         else if (!p0) begin
            n_checks++;
            if (run0 != 1) begin
               n_errors++;
               $display("FAIL corner_run0 cycle %0d: got %0d required 1", k, run0);
            end
            run0 = 0;
         end
         if (!b_an1_n) run1++;
         else if (!p1) begin
            n_checks++;
            if (run1 != 1) begin
               n_errors++;
               $display("FAIL corner_run1 cycle %0d: got %0d required 1", k, run1);
            end
            run1 = 0;
         end
         p0 = b_an0_n; p1 = b_an1_n;
      end
   endtask

   initial begin
      reset = 1'b1; s0 = 4'h0; s1 = 4'h0;
      ph_a = 0; ph_b = 0; m_sel_a = 4'h0; m_sel_b = 4'h0;
      test_reset();
      test_basic();
      test_freeze();
      test_random();
      test_reset_mid();
      test_corner();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_display_mux
